// File: rtl/lc3_bus_arbiter.sv
// Registered LC-3 shared-bus driver: N_SRC gated sources, lowest-index priority,
// contention detection with a sticky flag, saturating counter and optional strict fault mode.
module lc3_bus_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned CNT_W     = 8,
    parameter bit          STRICT    = 1'b0,
    parameter bit          IDLE_ZERO = 1'b0,
    localparam int unsigned IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic [N_SRC-1:0]       i_Gate,
    input  logic [N_SRC*WIDTH-1:0] i_Src_Data,
    input  logic                   i_Err_Clr,
    output logic [WIDTH-1:0]       o_Bus,
    output logic                   o_Bus_Valid,
    output logic [IDX_W-1:0]       o_Src_Idx,
    output logic                   o_Contention,
    output logic [CNT_W-1:0]       o_Cont_Count,
    output logic                   o_Fault
);

    typedef enum logic {StRun, StFault} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   bus_q, bus_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cont_q, cont_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_base;

    logic               any;
    logic               multi;
    logic [IDX_W-1:0]   win;
    logic [WIDTH-1:0]   win_data;

    // Descending scan so the lowest set gate is the last assignment to win.
    always_comb begin
        any   = 1'b0;
        multi = 1'b0;
        win   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (i_Gate[k]) begin
                win = IDX_W'(k);
            end
        end
        for (int k = 0; k < N_SRC; k++) begin
            if (i_Gate[k]) begin
                multi = multi | any;
                any   = 1'b1;
            end
        end
        win_data = i_Src_Data[win*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        bus_d    = bus_q;
        valid_d  = 1'b0;
        idx_d    = idx_q;
        cont_d   = cont_q;
        cnt_d    = cnt_q;
        cnt_base = i_Err_Clr ? '0 : cnt_q;

        unique case (state_q)
            StRun: begin
                if (i_Err_Clr) begin
                    cont_d = 1'b0;
                    cnt_d  = '0;
                end
                if (multi) begin
                    // Contention wins over a same-cycle clear.
                    cont_d = 1'b1;
                    cnt_d  = (cnt_base == {CNT_W{1'b1}}) ? cnt_base : cnt_base + 1'b1;
                    if (STRICT) begin
                        state_d = StFault;
                    end else begin
                        bus_d   = win_data;
                        idx_d   = win;
                        valid_d = 1'b1;
                    end
                end else if (any) begin
                    bus_d   = win_data;
                    idx_d   = win;
                    valid_d = 1'b1;
                end else if (IDLE_ZERO) begin
                    bus_d = '0;
                end
            end
            StFault: begin
                if (i_Err_Clr) begin
                    state_d = StRun;
                    cont_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= StRun;
            bus_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            cont_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            cont_q  <= cont_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_Bus        = bus_q;
    assign o_Bus_Valid  = valid_q;
    assign o_Src_Idx    = idx_q;
    assign o_Contention = cont_q;
    assign o_Cont_Count = cnt_q;
    assign o_Fault      = (state_q == StFault);

endmodule

// File: tb/tb_lc3_bus_arbiter.sv
// Bench for lc3_bus_arbiter: a priority/idle-hold instance driven from a vector table,
// and a strict/idle-zero instance driven by hand-written fault and reset sequences.
module tb_lc3_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  gate_a, gate_b;
    logic [63:0] data_a, data_b;
    logic        clr_a, clr_b;

    logic [15:0] bus_a, bus_b;
    logic        valid_a, valid_b;
    logic [1:0]  idx_a, idx_b;
    logic        cont_a, cont_b;
    logic [7:0]  cnt_a, cnt_b;
    logic        fault_a, fault_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_bus_arbiter #(
        .WIDTH(16), .N_SRC(4), .CNT_W(8), .STRICT(1'b0), .IDLE_ZERO(1'b0)
    ) dut_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Gate(gate_a), .i_Src_Data(data_a),
        .i_Err_Clr(clr_a), .o_Bus(bus_a), .o_Bus_Valid(valid_a), .o_Src_Idx(idx_a),
        .o_Contention(cont_a), .o_Cont_Count(cnt_a), .o_Fault(fault_a)
    );

    lc3_bus_arbiter #(
        .WIDTH(16), .N_SRC(4), .CNT_W(8), .STRICT(1'b1), .IDLE_ZERO(1'b1)
    ) dut_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Gate(gate_b), .i_Src_Data(data_b),
        .i_Err_Clr(clr_b), .o_Bus(bus_b), .o_Bus_Valid(valid_b), .o_Src_Idx(idx_b),
        .o_Contention(cont_b), .o_Cont_Count(cnt_b), .o_Fault(fault_b)
    );

    typedef struct {
        logic [3:0]  gate;
        logic [63:0] data;
        logic        clr;
        logic [15:0] bus;
        logic        valid;
        logic [1:0]  idx;
        logic        cont;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [63:0] pk(input logic [15:0] s0, input logic [15:0] s1,
                                       input logic [15:0] s2, input logic [15:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    function automatic vec_t mk(input logic [3:0] g, input logic [63:0] d, input logic c,
                                input logic [15:0] b, input logic v, input logic [1:0] i,
                                input logic ct, input logic [7:0] n);
        vec_t r;
        r.gate = g; r.data = d; r.clr = c; r.bus = b;
        r.valid = v; r.idx = i; r.cont = ct; r.cnt = n;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_b(input string tag, input logic [15:0] b, input logic v,
                           input logic [1:0] i, input logic ct, input logic [7:0] n,
                           input logic f);
        check({tag, "_bus"}, bus_b, b);
        check({tag, "_valid"}, valid_b, v);
        check({tag, "_idx"}, idx_b, i);
        check({tag, "_cont"}, cont_b, ct);
        check({tag, "_cnt"}, cnt_b, n);
        check({tag, "_fault"}, fault_b, f);
    endtask

    initial begin
        vecs[0]  = mk(4'b0100, pk(16'h0, 16'h0, 16'hBEEF, 16'h0), 1'b0, 16'hBEEF, 1, 2, 0, 0);
        vecs[1]  = mk(4'b0001, pk(16'h1234, 16'h0, 16'h0, 16'h0), 1'b0, 16'h1234, 1, 0, 0, 0);
        vecs[2]  = mk(4'b0000, pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 1'b0,
                      16'h1234, 0, 0, 0, 0);
        vecs[3]  = mk(4'b1000, pk(16'h0, 16'h0, 16'h0, 16'h5678), 1'b0, 16'h5678, 1, 3, 0, 0);
        vecs[4]  = mk(4'b0000, pk(16'h1, 16'h2, 16'h3, 16'h4), 1'b0, 16'h5678, 0, 3, 0, 0);
        vecs[5]  = mk(4'b1010, pk(16'h0, 16'h0011, 16'h0, 16'h0033), 1'b0, 16'h0011, 1, 1, 1, 1);
        vecs[6]  = mk(4'b1111, pk(16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD), 1'b0,
                      16'h0AAA, 1, 0, 1, 2);
        vecs[7]  = mk(4'b0000, pk(16'h0, 16'h0, 16'h0, 16'h0), 1'b0, 16'h0AAA, 0, 0, 1, 2);
        vecs[8]  = mk(4'b0010, pk(16'h0, 16'h7777, 16'h0, 16'h0), 1'b1, 16'h7777, 1, 1, 0, 0);
        vecs[9]  = mk(4'b0100, pk(16'h0, 16'h0, 16'h2222, 16'h0), 1'b0, 16'h2222, 1, 2, 0, 0);
        for (int k = 0; k < 5; k++) begin
            vecs[10+k] = mk(4'b0110, pk(16'h0, 16'h0101, 16'h0202, 16'h0), 1'b0,
                            16'h0101, 1, 1, 1, 8'(k + 1));
        end
        // Clear coinciding with contention: count restarts at 1, flag stays set.
        vecs[15] = mk(4'b0110, pk(16'h0, 16'h0101, 16'h0202, 16'h0), 1'b1, 16'h0101, 1, 1, 1, 1);

        rst_n  = 1'b0;
        gate_a = '0; data_a = '0; clr_a = 1'b0;
        gate_b = '0; data_b = '0; clr_b = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_a_bus", bus_a, 0);
        check("rst_a_valid", valid_a, 0);
        check("rst_a_cnt", cnt_a, 0);
        check_b("rst_b", 16'h0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            gate_a = vecs[i].gate;
            data_a = vecs[i].data;
            clr_a  = vecs[i].clr;
            tick();
            check($sformatf("v%0d_bus", i), bus_a, vecs[i].bus);
            check($sformatf("v%0d_valid", i), valid_a, vecs[i].valid);
            check($sformatf("v%0d_idx", i), idx_a, vecs[i].idx);
            check($sformatf("v%0d_cont", i), cont_a, vecs[i].cont);
            check($sformatf("v%0d_cnt", i), cnt_a, vecs[i].cnt);
            check($sformatf("v%0d_fault", i), fault_a, 0);
        end

        // Saturation: 300 contention cycles starting from a clear.
        gate_a = 4'b1010;
        data_a = pk(16'h0, 16'h0011, 16'h0, 16'h0033);
        clr_a  = 1'b1;
        tick();
        clr_a  = 1'b0;
        for (int k = 1; k < 300; k++) begin
            tick();
            if (k == 254) check("sat_cnt_254", cnt_a, 255);
        end
        check("sat_cnt", cnt_a, 255);
        check("sat_bus", bus_a, 16'h0011);
        check("sat_idx", idx_a, 1);
        check("sat_cont", cont_a, 1);
        gate_a = '0;
        clr_a  = 1'b0;

        // Strict instance: legal drive, contention fault, ignored gates, clear, recovery.
        gate_b = 4'b0001;
        data_b = pk(16'hAAAA, 16'h5555, 16'h1111, 16'h0);
        tick();
        check_b("s_drive", 16'hAAAA, 1, 0, 0, 0, 0);
        gate_b = 4'b0011;
        tick();
        check_b("s_fault", 16'hAAAA, 0, 0, 1, 1, 1);
        gate_b = 4'b0100;
        tick();
        check_b("s_ign1", 16'hAAAA, 0, 0, 1, 1, 1);
        gate_b = 4'b0110;
        tick();
        check_b("s_ign2", 16'hAAAA, 0, 0, 1, 1, 1);
        gate_b = 4'b0100;
        clr_b  = 1'b1;
        tick();
        check_b("s_clr", 16'hAAAA, 0, 0, 0, 0, 0);
        clr_b  = 1'b0;
        tick();
        check_b("s_recover", 16'h1111, 1, 2, 0, 0, 0);
        gate_b = 4'b0000;
        tick();
        check_b("s_idle0", 16'h0, 0, 2, 0, 0, 0);
        gate_b = 4'b0011;
        tick();
        check_b("s_fault2", 16'h0, 0, 2, 1, 1, 1);

        // Asynchronous reset while in FAULT, checked with no clock edge in between.
        gate_b = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        check_b("s_areset", 16'h0, 0, 0, 0, 0, 0);
        check("a_areset_bus", bus_a, 0);
        check("a_areset_cnt", cnt_a, 0);
        #2 rst_n = 1'b1;
        gate_b = 4'b0100;
        data_b = pk(16'h0, 16'h0, 16'hBEEF, 16'h0);
        tick();
        check_b("s_post_rst", 16'hBEEF, 1, 2, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_bus_arbiter.md
# lc3_bus_arbiter

Parametrised, registered driver for the LC-3 shared datapath bus. It replaces the fixed three-gate priority driver with N_SRC gated sources and configurable width. It adds per-cycle contention detection, a sticky error flag with a saturating event counter, and an optional strict mode that freezes the bus on contention until software-visible clear. It sits between the datapath source units (MARMUX, ALU, MDR, PC, …) and every bus consumer (MAR, MDR, IR, PC, register file).

## Interface
Parameters:
- WIDTH, 16, bus data width in bits.
- N_SRC, 4, number of gated sources. LC-3 mapping: 0 = MARMUX, 1 = ALU, 2 = MDR, 3 = PC.
- CNT_W, 8, width of the contention counter.
- STRICT, 0, contention policy. 0 = lowest-index source wins. 1 = enter FAULT and stop driving.
- IDLE_ZERO, 0, no-gate behaviour. 0 = bus holds its last value. 1 = bus loads 0.

Ports. IDX_W = max(1, $clog2(N_SRC)).
- i_Clk  input  1  system clock; all state updates on rising edge.
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_Gate  input  N_SRC  per-source gate enables; bit k gates source k.
- i_Src_Data  input  N_SRC*WIDTH  packed source data; source k occupies bits [k*WIDTH +: WIDTH].
- i_Err_Clr  input  1  single-cycle clear of contention flag, counter and FAULT state.
- o_Bus  output  WIDTH  registered bus value.
- o_Bus_Valid  output  1  high for the cycle after a source was legally driven.
- o_Src_Idx  output  IDX_W  index of the source that produced the current o_Bus.
- o_Contention  output  1  sticky; set when ≥2 gates were high in one cycle.
- o_Cont_Count  output  CNT_W  number of contention cycles, saturating.
- o_Fault  output  1  high while the FSM is in FAULT (STRICT=1 only).

## Operation
- Two-state FSM: RUN and FAULT. Reset state is RUN. FAULT is reachable only when STRICT=1.
- Combinational per cycle:
  - any = OR(i_Gate).
  - multi = popcount(i_Gate) ≥ 2.
  - win = lowest set index of i_Gate.
- RUN, any=1 and multi=0:
  - o_Bus ← source[win], o_Src_Idx ← win, o_Bus_Valid ← 1.
- RUN, any=0:
  - o_Bus holds (IDLE_ZERO=0) or ← 0 (IDLE_ZERO=1).
  - o_Bus_Valid ← 0, o_Src_Idx holds.
- RUN, multi=1:
  - o_Contention ← 1.
  - o_Cont_Count ← o_Cont_Count+1, saturating at 2^CNT_W−1 (no wrap).
  - STRICT=0: drive source[win] exactly as in the legal case, with o_Bus_Valid ← 1.
  - STRICT=1: o_Bus and o_Src_Idx hold, o_Bus_Valid ← 0, state → FAULT.
- FAULT:
  - All gates are ignored and the counter does not advance.
  - o_Bus and o_Src_Idx hold, o_Bus_Valid = 0, o_Fault = 1.
  - i_Err_Clr=1 → state RUN, o_Contention ← 0, o_Cont_Count ← 0. Gates presented in that same cycle are ignored.
- i_Err_Clr in RUN: clears the flag and counter.
  - If multi=1 in the same cycle, contention takes priority: o_Contention ends at 1 and o_Cont_Count at 1.
  - Bus behaviour in that cycle follows the normal RUN rules.
- Reset (i_Rst_n low, asynchronous, effective immediately and at any point in operation):
  - o_Bus = 0, o_Bus_Valid = 0, o_Src_Idx = 0, o_Contention = 0, o_Cont_Count = 0, o_Fault = 0, state = RUN.
  - Any drive in progress is discarded.
- N_SRC=1: multi is constantly 0, and o_Src_Idx is 1 bit wide and always 0.

## Timing
- Latency: exactly 1 cycle from gate/data sampled at edge n to o_Bus/o_Bus_Valid/o_Src_Idx valid after edge n.
- o_Contention, o_Cont_Count and o_Fault update on the same edge that samples the offending gates.
- No combinational path from any input to any output; all outputs are registers.
- Recovery from FAULT: i_Err_Clr high at edge n → RUN after n. Gates sampled at edge n+1 drive the bus after n+1.
- Reset release is synchronous-safe: first functional edge is the first rising i_Clk with i_Rst_n high.

## Test plan
- Reset, single source: reset, then i_Gate=4'b0100, source 2 = 16'hBEEF. After 1 edge: o_Bus=16'hBEEF, o_Src_Idx=2, o_Bus_Valid=1, o_Contention=0.
- Idle behaviour: after o_Bus=16'h1234, set i_Gate=0. IDLE_ZERO=0 → o_Bus stays 16'h1234 with o_Bus_Valid=0. IDLE_ZERO=1 → o_Bus=0.
- Priority contention (STRICT=0): i_Gate=4'b1010, src1=16'h0011, src3=16'h0033. Expect o_Bus=16'h0011, o_Src_Idx=1, o_Contention=1, o_Cont_Count=1. Repeat 300 cycles with CNT_W=8 → o_Cont_Count saturates at 255.
- Strict fault: STRICT=1, o_Bus=16'hAAAA, then i_Gate=4'b0011.
  - Expect o_Fault=1, o_Bus=16'hAAAA, o_Bus_Valid=0.
  - Further legal gates are ignored.
  - i_Err_Clr pulse → o_Fault=0, count=0; next legal gate drives normally.
- Simultaneous clear and contention in RUN: i_Err_Clr=1 with i_Gate=4'b0110 and prior count 5 → o_Contention=1, o_Cont_Count=1.
- Async reset mid-operation: assert i_Rst_n low between edges while in FAULT → all outputs 0 immediately with no clock edge; after release a legal gate drives on the first edge.
